jtcop_pal_dma: RTL and testbench

Palette copy engine that feeds the video-side palette RAM read by the colour mixer. The CPU fills a staging buffer and requests a transfer; the block copies every staging word into the palette RAM write port, and only while vertical blank is active, so the mixer never reads a half-updated palette mid-frame. It sits between the staging buffer's read port and the palette dual-port RAM's write port, all on the video clock.

---
 rtl/jtcop_pal_dma.sv | 119 +++++++++++
 tb/tb_jtcop_pal_dma.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_pal_dma.sv
// rtl/jtcop_pal_dma.sv - palette copy engine, staging buffer to palette RAM during vertical blank
// Reads are issued only while LVBL=0; each read turns into a palette write on the following cycle.
module jtcop_pal_dma #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          LVBL,
   input  logic          dma_trig,
   output logic [AW-1:0] buf_addr,
   input  logic [15:0]   buf_data,
   output logic [AW-1:0] pal_addr,
   output logic [15:0]   pal_dout,
   output logic [1:0]    pal_we,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {IDLE, WAIT, COPY, FLUSH} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] buf_addr_q, buf_addr_d;
   logic [AW-1:0] pal_addr_q, pal_addr_d;
   logic [15:0]   pal_dout_q, pal_dout_d;
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pending_q, pending_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      buf_addr_d = buf_addr_q;
      pal_addr_d = pal_addr_q;
      pal_dout_d = pal_dout_q;
      rd_d       = 1'b0;
      wr_d       = rd_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      pending_d  = pending_q;

      if (rd_q) pal_addr_d = buf_addr_q;
      // buf_data is only valid during the write cycle, so it is captured as that cycle ends
      if (wr_q) pal_dout_d = buf_data;
      if (busy_q && dma_trig) pending_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (dma_trig) begin
               state_d = WAIT;
               busy_d  = 1'b1;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            if (!LVBL) state_d = COPY;
         end
         COPY: begin
            if (!LVBL) begin
               buf_addr_d = cnt_q;
               rd_d       = 1'b1;
               cnt_d      = cnt_q + AW'(1);
               if (&cnt_q) state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (!rd_q) begin
               done_d    = 1'b1;
               pending_d = 1'b0;
               // a request landing on this edge chains straight into the next transfer
               if (pending_q || dma_trig) begin
                  state_d = WAIT;
                  cnt_d   = '0;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         buf_addr_q <= '0;
         pal_addr_q <= '0;
         pal_dout_q <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pending_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         buf_addr_q <= buf_addr_d;
         pal_addr_q <= pal_addr_d;
         pal_dout_q <= pal_dout_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pending_q  <= pending_d;
      end
   end

   assign buf_addr = buf_addr_q;
   assign pal_addr = pal_addr_q;
   assign pal_dout = wr_q ? buf_data : pal_dout_q;
   assign pal_we   = {2{wr_q}};
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_jtcop_pal_dma.sv
// tb/tb_jtcop_pal_dma.sv - directed bench for jtcop_pal_dma
// Staging word k holds 16'hA000|k; a negedge monitor tallies palette writes for the directed steps.
module tb_jtcop_pal_dma;

   logic        clk = 1'b0;
   logic        rst;
   logic        LVBL;
   logic        dma_trig;
   logic [9:0]  buf_addr;
   logic [15:0] buf_data;
   logic [9:0]  pal_addr;
   logic [15:0] pal_dout;
   logic [1:0]  pal_we;
   logic        busy;
   logic        done;

   logic [15:0] mem [0:1023];

   int n_assert = 0;
   int n_fail   = 0;
   int nwr = 0, derr = 0, serr = 0, werr = 0, ndone = 0, nbf = 0;
   logic       busy_prev = 1'b0;
   logic [9:0] last_addr = 10'h3FF;

   always #5 clk = ~clk;

   jtcop_pal_dma #(.AW(10)) dut (
      .clk      (clk),
      .rst      (rst),
      .LVBL     (LVBL),
      .dma_trig (dma_trig),
      .buf_addr (buf_addr),
      .buf_data (buf_data),
      .pal_addr (pal_addr),
      .pal_dout (pal_dout),
      .pal_we   (pal_we),
      .busy     (busy),
      .done     (done)
   );

   always @(posedge clk) buf_data <= mem[buf_addr];

   always @(negedge clk) begin
      if (pal_we == 2'b11) begin
         nwr <= nwr + 1;
         if (pal_dout !== (16'hA000 | {6'd0, pal_addr})) derr <= derr + 1;
         if (pal_addr !== last_addr + 10'd1 && pal_addr !== 10'd0) serr <= serr + 1;
         last_addr <= pal_addr;
      end
      if (pal_we !== 2'b11 && pal_we !== 2'b00) werr <= werr + 1;
      if (done === 1'b1) ndone <= ndone + 1;
      if (busy_prev === 1'b1 && busy === 1'b0) nbf <= nbf + 1;
      busy_prev <= busy;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag, input int limit, output int n);
      n = 0;
      while (done !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      chk(tag, 32'(done), 32'd1);
   endtask

   task automatic pulse_trig();
      dma_trig = 1'b1;
      tick();
      dma_trig = 1'b0;
   endtask

   initial begin
      int n, w0, s0, d0, b0;
      for (int k = 0; k < 1024; k++) mem[k] = 16'hA000 | 16'(k);
      rst = 1'b1; LVBL = 1'b1; dma_trig = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_we", 32'(pal_we), 32'd0);
      chk("rst_buf_addr", 32'(buf_addr), 32'd0);
      chk("rst_pal_addr", 32'(pal_addr), 32'd0);
      chk("rst_pal_dout", 32'(pal_dout), 32'd0);

      // basic copy with LVBL held low
      LVBL = 1'b0;
      w0 = nwr; s0 = serr; d0 = ndone;
      pulse_trig();
      chk("basic_busy_on", 32'(busy), 32'd1);
      tick(); tick();
      chk("basic_no_early_we", 32'(pal_we), 32'd0);
      tick();
      chk("basic_first_we", 32'(pal_we), 32'h3);
      chk("basic_first_addr", 32'(pal_addr), 32'd0);
      chk("basic_first_data", 32'(pal_dout), 32'hA000);
      wait_done("basic_done_seen", 2000, n);
      chk("basic_done_latency", 32'(n), 32'd1024);
      chk("basic_busy_at_done", 32'(busy), 32'd0);
      tick();
      chk("basic_done_single", 32'(done), 32'd0);
      repeat (3) tick();
      chk("basic_writes", 32'(nwr - w0), 32'd1024);
      chk("basic_seq", 32'(serr - s0), 32'd0);
      chk("basic_done_count", 32'(ndone - d0), 32'd1);

      // blank gating
      LVBL = 1'b1;
      w0 = nwr;
      pulse_trig();
      repeat (50) tick();
      chk("gate_no_writes", 32'(nwr - w0), 32'd0);
      chk("gate_busy", 32'(busy), 32'd1);
      LVBL = 1'b0;
      tick(); tick();
      chk("gate_we_before", 32'(pal_we), 32'd0);
      tick();
      chk("gate_first_we", 32'(pal_we), 32'h3);
      chk("gate_first_addr", 32'(pal_addr), 32'd0);
      wait_done("gate_done_seen", 2000, n);
      repeat (3) tick();
      chk("gate_writes", 32'(nwr - w0), 32'd1024);

      // pause after 300 reads, resume at 300
      w0 = nwr; s0 = serr;
      pulse_trig();
      repeat (301) tick();
      LVBL = 1'b1;
      repeat (100) tick();
      chk("pause_writes", 32'(nwr - w0), 32'd300);
      chk("pause_last_addr", 32'(pal_addr), 32'd299);
      chk("pause_we_off", 32'(pal_we), 32'd0);
      LVBL = 1'b0;
      tick(); tick();
      chk("resume_we", 32'(pal_we), 32'h3);
      chk("resume_addr", 32'(pal_addr), 32'd300);
      wait_done("pause_done_seen", 2000, n);
      repeat (3) tick();
      chk("pause_total", 32'(nwr - w0), 32'd1024);
      chk("pause_seq", 32'(serr - s0), 32'd0);

      // three requests during a transfer queue exactly one more
      w0 = nwr; d0 = ndone; b0 = nbf;
      pulse_trig();
      repeat (3) begin
         repeat (100) tick();
         pulse_trig();
      end
      wait_done("queue_done1", 2000, n);
      chk("queue_busy_held", 32'(busy), 32'd1);
      tick();
      wait_done("queue_done2", 2000, n);
      chk("queue_busy_end", 32'(busy), 32'd0);
      repeat (20) tick();
      chk("queue_writes", 32'(nwr - w0), 32'd2048);
      chk("queue_done_count", 32'(ndone - d0), 32'd2);
      chk("queue_busy_falls", 32'(nbf - b0), 32'd1);

      // asynchronous reset at address 500
      pulse_trig();
      n = 0;
      while (!(pal_we === 2'b11 && pal_addr === 10'd500) && n < 1000) begin
         tick();
         n++;
      end
      chk("rstmid_reach_500", 32'(pal_addr), 32'd500);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_we", 32'(pal_we), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      w0 = nwr;
      tick();
      rst = 1'b0;
      repeat (20) tick();
      chk("rstmid_no_writes", 32'(nwr - w0), 32'd0);
      chk("rstmid_idle", 32'(busy), 32'd0);

      // trigger on the edge that produces done
      d0 = ndone; b0 = nbf;
      pulse_trig();
      repeat (1026) tick();
      dma_trig = 1'b1;
      tick();
      dma_trig = 1'b0;
      chk("edge_done", 32'(done), 32'd1);
      chk("edge_busy", 32'(busy), 32'd1);
      tick(); tick();
      chk("edge_gap_we", 32'(pal_we), 32'd0);
      tick();
      chk("edge_second_we", 32'(pal_we), 32'h3);
      chk("edge_second_addr", 32'(pal_addr), 32'd0);
      wait_done("edge_done2", 2000, n);
      repeat (5) tick();
      chk("edge_done_count", 32'(ndone - d0), 32'd2);
      chk("edge_busy_falls", 32'(nbf - b0), 32'd1);

      chk("all_data", 32'(derr), 32'd0);
      chk("all_we_encoding", 32'(werr), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
